param_datapath: RTL and testbench
=================================

PARAM_DATAPATH -- requirements
Module: param_datapath

Interface
REQ-001 Parameter WIDTH, default 16, datapath/bus/register width; legal values WIDTH >= 16.
REQ-002 Parameter NREGS, default 8, register-file depth; power of two >= 2; AW = clog2(NREGS).
REQ-003 Parameter PC_RESET, default 'h3000, PC value after reset.
REQ-004 Parameter TIMEOUT, default 15, memory wait cycles before abort; legal range 1..255.
REQ-005 One clock, clk; reset is synchronous and active-high, named reset.
REQ-006 Port clk  in  1  rising-edge clock for all state.
REQ-007 Port reset  in  1  synchronous active-high reset.
REQ-008 Port drv_sel  in  3  bus source: 0 none, 1 PC, 2 ALU, 3 MARMux, 4 MDR; 5-7 treated as none.
REQ-009 Port alu_op  in  2  00 ADD, 01 AND, 10 NOT A, 11 PASS A.
REQ-010 Ports sr1, sr2, dr  in  AW each  register-file read A, read B and write addresses.
REQ-011 Ports ld_ir, ld_pc, ld_mar, ld_mdr, ld_reg, ld_cc  in  1 each  load enables sampled at clk.
REQ-012 Port pc_sel  in  2  PC source: 00 PC+1, 01 bus, 10 EAB, 11 hold.
REQ-013 Ports eab1_sel  in  1 (0 PC, 1 RegA); eab2_sel  in  2 (00 zero, 01 sext IR[5:0], 10 sext IR[8:0], 11 sext IR[10:0]).
REQ-014 Port marm_sel  in  1  0 zext IR[7:0], 1 EAB output.
REQ-015 Ports mem_start, mem_we  in  1 each  start a memory transaction; mem_we=1 write, 0 read.
REQ-016 Ports mem_req, mem_wr  out  1 each; mem_addr, mem_wdata  out  WIDTH; mem_rdata  in  WIDTH; mem_ack  in  1.
REQ-017 Ports busy, timeout  out  1 each; ir  out  WIDTH; n, z, p  out  1 each.

Function
REQ-018 Bus is a registered-free mux selected by drv_sel; no tri-state drivers; bus = 0 when no source is selected.
REQ-019 ALU B operand = sext IR[4:0] when IR[5]=1, else RegB; arithmetic is modulo 2^WIDTH, no carry out.
REQ-020 EAB = eab1 operand + eab2 offset, modulo 2^WIDTH.
REQ-021 Register file: two asynchronous reads, one synchronous write of bus to dr when ld_reg=1; same-cycle read of dr returns the old value.
REQ-022 ld_cc=1: n = bus MSB, z = (bus == 0), p = neither; exactly one flag set at all times.
REQ-023 ld_ir loads bus into IR; ld_pc loads the pc_sel source.
REQ-024 Memory FSM states IDLE, REQ, ERR; mem_addr = MAR and mem_wdata = MDR continuously.
REQ-025 IDLE with mem_start=1 -> REQ next cycle; mem_req=1 and mem_wr=mem_we (latched) throughout REQ; busy=1 in REQ.
REQ-026 REQ with mem_ack=1 -> IDLE next cycle; on a read, MDR <= mem_rdata at that same edge.
REQ-027 REQ with mem_ack=0 for TIMEOUT consecutive cycles -> ERR; mem_req deasserts; timeout=1 (sticky).
REQ-028 ERR -> REQ on mem_start (clears timeout at the same edge); otherwise stays in ERR; busy=0 in ERR.
REQ-029 mem_start while in REQ is ignored; ld_mar and ld_mdr while in REQ are ignored (address/data stable).
REQ-030 ld_mdr in IDLE/ERR loads bus into MDR; mem_ack outside REQ is ignored.
REQ-031 Minimum read latency: mem_start at edge k, ack sampled at edge k+1, MDR valid after edge k+1.

Reset
REQ-032 reset=1 at a clk edge: PC=PC_RESET; IR, MAR, MDR and all registers = 0; n=0, z=1, p=0; FSM=IDLE; mem_req=0, busy=0, timeout=0.
REQ-033 Reset overrides all loads and aborts a transaction in REQ in the same cycle.

Verification
REQ-034 Reset, then drv_sel=1, ld_ir=1 -> IR='h3000; ld_pc with pc_sel=00 -> PC='h3001.
REQ-035 R1=5, IR[5:0]=6'b1_11101 (imm -3), alu_op=ADD, drv_sel=2, ld_reg to R2, ld_cc -> R2=2, n=0, z=0, p=1.
REQ-036 MAR='h4000, mem_start with mem_we=0, ack after 3 cycles with rdata='hBEEF -> busy high 3 cycles, MDR='hBEEF, mem_req low afterward.
REQ-037 Read with no ack, TIMEOUT=15 -> ERR after 15 REQ cycles, timeout=1; next mem_start clears it.
REQ-038 ld_mar='h1234 attempted mid-REQ -> mem_addr unchanged; reset asserted mid-REQ -> mem_req=0 next cycle.
REQ-039 WIDTH=32, NREGS=16: NOT of R15='h0000_0000 -> bus='hFFFF_FFFF, n=1.

Source files
------------

// File: rtl/param_datapath_if.sv
// Memory-side bus of param_datapath.
//   master (datapath): drives mem_req, mem_wr, mem_addr, mem_wdata;
//                      samples mem_rdata, mem_ack.
//   slave  (memory):   the reverse.
interface param_datapath_if #(
   parameter int unsigned WIDTH = 16
) ();
   logic             mem_req;
   logic             mem_wr;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] mem_rdata;
   logic             mem_ack;

   modport master (
      output mem_req, mem_wr, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_wr, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/param_datapath.sv
// Parameterised datapath: PC, IR, MAR, MDR, register file, ALU, EAB adder,
// MARMux, condition codes, single bus mux and a memory handshake FSM.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   drv_sel               bus source (0 none, 1 PC, 2 ALU, 3 MARMux, 4 MDR)
//   alu_op                00 ADD, 01 AND, 10 NOT A, 11 PASS A
//   sr1, sr2, dr          register-file read A / read B / write addresses
//   ld_*                  load enables
//   pc_sel                00 PC+1, 01 bus, 10 EAB, 11 hold
//   eab1_sel, eab2_sel    EAB base and offset selects
//   marm_sel              0 zext IR[7:0], 1 EAB
//   mem_start, mem_we     start a memory transaction (we=1 write)
//   mem                   memory bus (master side)
//   busy, timeout         transaction in progress / sticky abort flag
//   ir, n, z, p           instruction register and condition codes
module param_datapath #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned NREGS    = 8,
   parameter int unsigned PC_RESET = 'h3000,
   parameter int unsigned TIMEOUT  = 15,
   localparam int unsigned AW      = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       drv_sel,
   input  logic [1:0]       alu_op,
   input  logic [AW-1:0]    sr1,
   input  logic [AW-1:0]    sr2,
   input  logic [AW-1:0]    dr,
   input  logic             ld_ir,
   input  logic             ld_pc,
   input  logic             ld_mar,
   input  logic             ld_mdr,
   input  logic             ld_reg,
   input  logic             ld_cc,
   input  logic [1:0]       pc_sel,
   input  logic             eab1_sel,
   input  logic [1:0]       eab2_sel,
   input  logic             marm_sel,
   input  logic             mem_start,
   input  logic             mem_we,
   param_datapath_if.master mem,
   output logic             busy,
   output logic             timeout,
   output logic [WIDTH-1:0] ir,
   output logic             n,
   output logic             z,
   output logic             p
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_ERR} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             we_q, we_d;
   logic             timeout_q, timeout_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] ir_q, ir_d;
   logic [WIDTH-1:0] mar_q, mar_d;
   logic [WIDTH-1:0] mdr_q, mdr_d;
   logic [WIDTH-1:0] rf_q [NREGS];
   logic [WIDTH-1:0] rf_d [NREGS];
   logic             n_q, n_d, z_q, z_d, p_q, p_d;

   logic [WIDTH-1:0] reg_a, reg_b, alu_b, alu_out;
   logic [WIDTH-1:0] eab1, eab2, eab, marmux, bus;
   logic             in_req;

   assign reg_a  = rf_q[sr1];
   assign reg_b  = rf_q[sr2];
   assign in_req = (state_q == S_REQ);

   // ALU: immediate mode selected by IR[5]
   always_comb begin
      alu_b   = ir_q[5] ? {{(WIDTH-5){ir_q[4]}}, ir_q[4:0]} : reg_b;
      alu_out = '0;
      case (alu_op)
         2'b00:   alu_out = reg_a + alu_b;
         2'b01:   alu_out = reg_a & alu_b;
         2'b10:   alu_out = ~reg_a;
         default: alu_out = reg_a;
      endcase
   end

   always_comb begin
      eab1 = eab1_sel ? reg_a : pc_q;
      eab2 = '0;
      case (eab2_sel)
         2'b01:   eab2 = {{(WIDTH-6){ir_q[5]}},  ir_q[5:0]};
         2'b10:   eab2 = {{(WIDTH-9){ir_q[8]}},  ir_q[8:0]};
         2'b11:   eab2 = {{(WIDTH-11){ir_q[10]}}, ir_q[10:0]};
         default: eab2 = '0;
      endcase
      eab    = eab1 + eab2;
      marmux = marm_sel ? eab : {{(WIDTH-8){1'b0}}, ir_q[7:0]};
   end

   always_comb begin
      bus = '0;
      case (drv_sel)
         3'd1:    bus = pc_q;
         3'd2:    bus = alu_out;
         3'd3:    bus = marmux;
         3'd4:    bus = mdr_q;
         default: bus = '0;
      endcase
   end

   // Memory FSM next state
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      timeout_d = timeout_q;
      case (state_q)
         S_IDLE: begin
            if (mem_start) begin
               state_d = S_REQ;
               we_d    = mem_we;
               cnt_d   = '0;
            end
         end
         S_REQ: begin
            if (mem.mem_ack) begin
               state_d = S_IDLE;
            end else if (cnt_q == TO_LAST) begin
               state_d   = S_ERR;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_ERR: begin
            if (mem_start) begin
               state_d   = S_REQ;
               we_d      = mem_we;
               cnt_d     = '0;
               timeout_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Register next state; MAR/MDR frozen while a transaction is outstanding
   always_comb begin
      pc_d = pc_q;
      if (ld_pc) begin
         case (pc_sel)
            2'b00:   pc_d = pc_q + WIDTH'(1);
            2'b01:   pc_d = bus;
            2'b10:   pc_d = eab;
            default: pc_d = pc_q;
         endcase
      end
      ir_d  = ld_ir ? bus : ir_q;
      mar_d = (ld_mar && !in_req) ? bus : mar_q;
      mdr_d = mdr_q;
      if (in_req) begin
         if (mem.mem_ack && !we_q) mdr_d = mem.mem_rdata;
      end else if (ld_mdr) begin
         mdr_d = bus;
      end
      rf_d = rf_q;
      if (ld_reg) rf_d[dr] = bus;
      n_d = n_q;
      z_d = z_q;
      p_d = p_q;
      if (ld_cc) begin
         n_d = bus[WIDTH-1];
         z_d = (bus == '0);
         p_d = !bus[WIDTH-1] && (bus != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         timeout_q <= 1'b0;
         pc_q      <= WIDTH'(PC_RESET);
         ir_q      <= '0;
         mar_q     <= '0;
         mdr_q     <= '0;
         rf_q      <= '{default: '0};
         n_q       <= 1'b0;
         z_q       <= 1'b1;
         p_q       <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         timeout_q <= timeout_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         mar_q     <= mar_d;
         mdr_q     <= mdr_d;
         rf_q      <= rf_d;
         n_q       <= n_d;
         z_q       <= z_d;
         p_q       <= p_d;
      end
   end

   assign mem.mem_req   = in_req;
   assign mem.mem_wr    = in_req && we_q;
   assign mem.mem_addr  = mar_q;
   assign mem.mem_wdata = mdr_q;
   assign busy          = in_req;
   assign timeout       = timeout_q;
   assign ir            = ir_q;
   assign n             = n_q;
   assign z             = z_q;
   assign p             = p_q;
endmodule

// File: tb/tb_param_datapath.sv
module tb_param_datapath;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [2:0]  drv_sel;
   logic [1:0]  alu_op;
   logic [2:0]  sr1, sr2, dr;
   logic        ld_ir, ld_pc, ld_mar, ld_mdr, ld_reg, ld_cc;
   logic [1:0]  pc_sel;
   logic        eab1_sel;
   logic [1:0]  eab2_sel;
   logic        marm_sel, mem_start, mem_we;
   logic        busy_a, timeout_a, n_a, z_a, p_a;
   logic [15:0] ir_a;

   logic [2:0]  b_drv;
   logic [1:0]  b_alu;
   logic [3:0]  b_sr1;
   logic        b_ld_ir, b_ld_cc;
   logic        busy_b, timeout_b, n_b, z_b, p_b;
   logic [31:0] ir_b;

   int checks = 0;
   int errors = 0;

   param_datapath_if #(.WIDTH(16)) mem_a ();
   param_datapath_if #(.WIDTH(32)) mem_b ();

   param_datapath dut_a (
      .clk(clk), .reset(reset), .drv_sel(drv_sel), .alu_op(alu_op),
      .sr1(sr1), .sr2(sr2), .dr(dr),
      .ld_ir(ld_ir), .ld_pc(ld_pc), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
      .ld_reg(ld_reg), .ld_cc(ld_cc), .pc_sel(pc_sel),
      .eab1_sel(eab1_sel), .eab2_sel(eab2_sel), .marm_sel(marm_sel),
      .mem_start(mem_start), .mem_we(mem_we), .mem(mem_a),
      .busy(busy_a), .timeout(timeout_a), .ir(ir_a),
      .n(n_a), .z(z_a), .p(p_a)
   );

   param_datapath #(.WIDTH(32), .NREGS(16)) dut_b (
      .clk(clk), .reset(reset), .drv_sel(b_drv), .alu_op(b_alu),
      .sr1(b_sr1), .sr2(4'd0), .dr(4'd0),
      .ld_ir(b_ld_ir), .ld_pc(1'b0), .ld_mar(1'b0), .ld_mdr(1'b0),
      .ld_reg(1'b0), .ld_cc(b_ld_cc), .pc_sel(2'b00),
      .eab1_sel(1'b0), .eab2_sel(2'b00), .marm_sel(1'b0),
      .mem_start(1'b0), .mem_we(1'b0), .mem(mem_b),
      .busy(busy_b), .timeout(timeout_b), .ir(ir_b),
      .n(n_b), .z(z_b), .p(p_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_ctl();
      drv_sel = 3'd0; alu_op = 2'b00; sr1 = '0; sr2 = '0; dr = '0;
      ld_ir = 0; ld_pc = 0; ld_mar = 0; ld_mdr = 0; ld_reg = 0; ld_cc = 0;
      pc_sel = 2'b00; eab1_sel = 0; eab2_sel = 2'b00; marm_sel = 0;
      mem_start = 0; mem_we = 0;
   endtask

   // Read with ack presented during REQ cycle number wc (1 = minimum latency)
   task automatic do_read(input logic [15:0] data, input int wc);
      mem_start = 1; mem_we = 0;
      step();
      mem_start = 0;
      chk("rd_wr_low", mem_a.mem_wr, 0);
      for (int i = 1; i <= wc; i++) begin
         chk("rd_busy", busy_a, 1);
         chk("rd_req", mem_a.mem_req, 1);
         if (i == wc) begin
            mem_a.mem_ack = 1; mem_a.mem_rdata = data;
         end
         step();
      end
      mem_a.mem_ack = 0;
      chk("rd_busy_done", busy_a, 0);
      chk("rd_req_done", mem_a.mem_req, 0);
      chk("rd_mdr", mem_a.mem_wdata, data);
   endtask

   initial begin
      reset = 1;
      clear_ctl();
      mem_a.mem_ack = 0; mem_a.mem_rdata = '0;
      mem_b.mem_ack = 0; mem_b.mem_rdata = '0;
      b_drv = 0; b_alu = 0; b_sr1 = 0; b_ld_ir = 0; b_ld_cc = 0;

      // Reset state
      step();
      chk("rst_ir", ir_a, 0);
      chk("rst_n", n_a, 0);
      chk("rst_z", z_a, 1);
      chk("rst_p", p_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_req", mem_a.mem_req, 0);
      chk("rst_timeout", timeout_a, 0);
      chk("rst_addr", mem_a.mem_addr, 0);
      chk("rst_wdata", mem_a.mem_wdata, 0);
      chk("rst_b_busy", busy_b, 0);
      chk("rst_b_z", z_b, 1);

      // PC onto bus into IR, PC+1; wide instance: NOT of R15 = 0
      reset = 0;
      drv_sel = 3'd1; ld_ir = 1; ld_pc = 1; pc_sel = 2'b00;
      b_drv = 3'd2; b_alu = 2'b10; b_sr1 = 4'd15; b_ld_ir = 1; b_ld_cc = 1;
      step();
      chk("ir_pc_reset", ir_a, 'h3000);
      chk("b_not_bus", ir_b, 'hFFFF_FFFF);
      chk("b_n", n_b, 1);
      chk("b_z", z_b, 0);
      chk("b_p", p_b, 0);
      chk("b_timeout", timeout_b, 0);
      b_ld_ir = 0; b_ld_cc = 0; b_drv = 0;
      ld_pc = 0;
      step();
      chk("ir_pc_inc", ir_a, 'h3001);

      // PC <= PC + sext(IR[5:0]) = 3001 + 1
      clear_ctl();
      ld_pc = 1; pc_sel = 2'b10; eab1_sel = 0; eab2_sel = 2'b01;
      step();
      clear_ctl();
      drv_sel = 3'd1; ld_ir = 1;
      step();
      chk("pc_eab", ir_a, 'h3002);

      // drv_sel 5 drives zero
      drv_sel = 3'd5;
      step();
      chk("bus_none", ir_a, 0);
      clear_ctl();

      // MAR <= 'h4000 via MDR; then 3-cycle read of BEEF
      do_read(16'h4000, 1);
      drv_sel = 3'd4; ld_mar = 1;
      step();
      clear_ctl();
      chk("mar_load", mem_a.mem_addr, 'h4000);
      do_read(16'hBEEF, 3);

      // R1 <= 5; IR <= 'h003D (imm -3)
      do_read(16'h0005, 2);
      drv_sel = 3'd4; ld_reg = 1; dr = 3'd1;
      step();
      clear_ctl();
      do_read(16'h003D, 1);
      drv_sel = 3'd4; ld_ir = 1;
      step();
      clear_ctl();
      chk("ir_imm", ir_a, 'h003D);

      // R2 <= R1 + (-3) = 2, cc positive
      drv_sel = 3'd2; alu_op = 2'b00; sr1 = 3'd1; dr = 3'd2; ld_reg = 1; ld_cc = 1;
      step();
      chk("add_imm_n", n_a, 0);
      chk("add_imm_z", z_a, 0);
      chk("add_imm_p", p_a, 1);
      clear_ctl();
      drv_sel = 3'd2; alu_op = 2'b11; sr1 = 3'd2; ld_ir = 1;
      step();
      chk("r2_value", ir_a, 2);

      // NOT R2 written back to R2: same-edge read sees old value
      alu_op = 2'b10; ld_reg = 1; dr = 3'd2; ld_cc = 1;
      step();
      chk("not_old", ir_a, 'hFFFD);
      chk("not_n", n_a, 1);
      chk("not_p", p_a, 0);
      clear_ctl();

      // Register-mode ADD wraps: 5 + FFFD = 2; AND = 5
      ld_ir = 1;
      step();
      drv_sel = 3'd2; alu_op = 2'b00; sr1 = 3'd1; sr2 = 3'd2; ld_ir = 1; ld_cc = 1;
      step();
      chk("add_reg_wrap", ir_a, 2);
      chk("add_reg_p", p_a, 1);
      alu_op = 2'b01;
      step();
      chk("and_reg", ir_a, 5);
      clear_ctl();
      ld_cc = 1;
      step();
      chk("cc_zero_z", z_a, 1);
      chk("cc_zero_n", n_a, 0);
      chk("cc_zero_p", p_a, 0);
      clear_ctl();

      // Write transaction; MAR/MDR loads ignored while in REQ
      mem_start = 1; mem_we = 1;
      step();
      clear_ctl();
      chk("wr_wr", mem_a.mem_wr, 1);
      chk("wr_req", mem_a.mem_req, 1);
      drv_sel = 3'd1; ld_mar = 1; ld_mdr = 1;
      step();
      clear_ctl();
      chk("wr_mar_hold", mem_a.mem_addr, 'h4000);
      chk("wr_mdr_hold", mem_a.mem_wdata, 'h003D);
      mem_a.mem_ack = 1; mem_a.mem_rdata = 16'h1111;
      step();
      mem_a.mem_ack = 0;
      chk("wr_done", busy_a, 0);
      chk("wr_mdr_kept", mem_a.mem_wdata, 'h003D);
      chk("wr_wr_low", mem_a.mem_wr, 0);

      // Timeout: 15 REQ cycles without ack
      mem_start = 1; mem_we = 0;
      step();
      mem_start = 0;
      for (int i = 1; i <= 15; i++) begin
         chk("to_busy", busy_a, 1);
         step();
      end
      chk("to_flag", timeout_a, 1);
      chk("to_busy_err", busy_a, 0);
      chk("to_req_err", mem_a.mem_req, 0);
      mem_a.mem_ack = 1;
      step();
      mem_a.mem_ack = 0;
      chk("to_sticky", timeout_a, 1);
      chk("to_ack_ign", busy_a, 0);
      mem_start = 1;
      step();
      mem_start = 0;
      chk("to_clear", timeout_a, 0);
      chk("to_rereq", busy_a, 1);
      mem_a.mem_ack = 1; mem_a.mem_rdata = 16'hA5A5;
      step();
      mem_a.mem_ack = 0;
      chk("to_read", mem_a.mem_wdata, 'hA5A5);

      // Reset aborts REQ
      mem_start = 1;
      step();
      mem_start = 0;
      chk("abort_req", mem_a.mem_req, 1);
      drv_sel = 3'd4; ld_mar = 1;
      step();
      chk("mid_mar_hold", mem_a.mem_addr, 'h4000);
      clear_ctl();
      reset = 1;
      step();
      reset = 0;
      chk("abort_req_low", mem_a.mem_req, 0);
      chk("abort_busy", busy_a, 0);
      chk("abort_mar", mem_a.mem_addr, 0);
      step();
      chk("abort_stay", mem_a.mem_req, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
